// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request, holds the fetched word.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rdi,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_out_q;
  logic [XLEN-1:0]   instr_q;
  logic              valid_q;
  logic              drop_q;
  logic              trap_c;
  logic [XLEN-1:0]   redir_pc_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign trap_c = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky fault flag; the FAULT state itself ignores further redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (state_q != ST_FAULT && trap_c) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign trap_c      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // A trapping redirect keeps the raw target so the handler can see it.
  assign redir_pc_c = trap_c ? redirect_pc : (redirect_pc & ~XLEN'(3));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else if (state_q != ST_FAULT && redirect_valid) begin
      pc_q    <= redir_pc_c;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      if (trap_c) begin
        state_q <= ST_FAULT;
      end else begin
        case (state_q)
          ST_REQ: begin
            // Old address already handed to memory: its response must be dropped.
            if (imem_req_ready) begin
              state_q <= ST_WAIT;
              drop_q  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              state_q <= ST_REQ;
              drop_q  <= 1'b0;
            end else begin
              drop_q  <= 1'b1;
            end
          end
          default: state_q <= ST_REQ;
        endcase
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
            end else begin
              instr_q  <= imem_rsp_data;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              state_q  <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_q    <= pc_q + XLEN'(4);
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state_q <= ST_REQ;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + XLEN'(4);
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign rdi         = instr_q[11:7];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stimulus against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [4:0]  rs1, rs2, rdi;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .rs1(rs1), .rs2(rs2), .rdi(rdi),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, an optional stale flag, one held word.
  logic [31:0] m_pc = RST_PC, m_instr = NOP, m_pcout = RST_PC;
  bit m_out = 0, m_stale = 0, m_valid = 0, m_fault = 0;

  function automatic bit m_req();
    return !m_out && !m_valid && !m_fault;
  endfunction

  function automatic bit misaligned_trap(input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
`ifdef FETCH_MISALIGN_TRAP_EN
    return lo != 2'b00;
`else
    return (lo != 2'b00) && 1'b0;
`endif
  endfunction

  task automatic model_step(input bit acc);
    if (reset) begin
      m_pc = RST_PC; m_pcout = RST_PC; m_instr = NOP;
      m_out = 0; m_stale = 0; m_valid = 0; m_fault = 0;
    end else if (!m_fault) begin
      if (redirect_valid) begin
        m_valid = 0; m_instr = NOP;
        if (misaligned_trap(redirect_pc)) begin
          m_fault = 1; m_pc = redirect_pc; m_out = 0; m_stale = 0;
        end else begin
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          if (acc) begin
            m_out = 1; m_stale = 1;
          end else if (m_out) begin
            if (imem_rsp_valid) begin m_out = 0; m_stale = 0; end
            else m_stale = 1;
          end
        end
      end else if (acc) begin
        m_out = 1;
      end else if (m_out && imem_rsp_valid) begin
        m_out = 0;
        if (m_stale) m_stale = 0;
        else begin m_valid = 1; m_instr = imem_rsp_data; m_pcout = m_pc; end
      end else if (m_valid && instr_ready) begin
        m_valid = 0; m_instr = NOP; m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Instruction memory: answers one accepted request after a configurable latency.
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  int          lat_mode = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_81B3;
    if (a == 32'h4) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = m_req() && imem_req_ready && !reset;
    if (reset) begin
      mem_busy = 0;
    end else begin
      if (imem_rsp_valid) mem_busy = 0;
      if (acc) begin
        mem_busy = 1; mem_addr = m_pc;
        mem_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end else if (mem_busy && mem_cnt > 0) begin
        mem_cnt--;
      end
    end
    model_step(acc);
    #1;
    imem_rsp_valid = mem_busy && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? data_of(mem_addr) : $urandom;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("imem_req", imem_req, m_req());
      check32("imem_addr", imem_addr, m_pc);
      check32("instr_valid", instr_valid, m_valid);
      check32("instr_out", instr_out, m_instr);
      check32("pc_out", pc_out, m_pcout);
      check32("pc_plus4", pc_plus4, m_pcout + 32'd4);
      check32("rs1", rs1, m_instr[19:15]);
      check32("rs2", rs2, m_instr[24:20]);
      check32("rdi", rdi, m_instr[11:7]);
      check32("fetch_fault", fetch_fault, m_fault);
    end
  end

  initial begin
    reset = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    tick(); tick();
    chk_en = 1; reset = 0;
    @(negedge clk);
    check32("rst_req", imem_req, 1); check32("rst_addr", imem_addr, 32'h0);
    check32("rst_valid", instr_valid, 0); check32("rst_instr", instr_out, NOP);
    check32("rst_fault", fetch_fault, 0);

    // First fetch with zero-wait memory.
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    @(negedge clk); check32("wait_req", imem_req, 0);
    tick();
    @(negedge clk);
    check32("first_valid", instr_valid, 1); check32("first_instr", instr_out, 32'h0020_81B3);
    check32("first_rs1", rs1, 5'd1); check32("first_rs2", rs2, 5'd2); check32("first_rdi", rdi, 5'd3);
    check32("first_pc", pc_out, 32'h0); check32("first_pcp4", pc_plus4, 32'h4);

    // Datapath stalls: the held word stays put and no requests go out.
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      check32("stall_instr", instr_out, 32'h0020_81B3);
      check32("stall_pc", pc_out, 32'h0); check32("stall_req", imem_req, 0);
    end
    instr_ready = 1; tick(); instr_ready = 0;
    @(negedge clk); check32("next_addr", imem_addr, 32'h4); check32("next_req", imem_req, 1);

    // Redirect while waiting; the stale response for address 4 must be dropped.
    lat_mode = 1; imem_req_ready = 1; tick(); imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h100; tick(); redirect_valid = 0;
    @(negedge clk); check32("drop_wait_req", imem_req, 0);
    tick();
    @(negedge clk);
    check32("drop_addr", imem_addr, 32'h100); check32("drop_req", imem_req, 1);
    check32("drop_instr", instr_out, NOP); check32("drop_valid", instr_valid, 0);

    // Redirect beats consumption in HOLD.
    lat_mode = 0; imem_req_ready = 1; tick(); imem_req_ready = 0; tick();
    @(negedge clk); check32("hold_valid", instr_valid, 1); check32("hold_pc", pc_out, 32'h100);
    redirect_valid = 1; redirect_pc = 32'h200; instr_ready = 1; tick();
    redirect_valid = 0; instr_ready = 0;
    @(negedge clk);
    check32("hredir_valid", instr_valid, 0); check32("hredir_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
    imem_req_ready = 1; tick(); imem_req_ready = 0; tick();
    @(negedge clk); check32("wrap_pc", pc_out, 32'hFFFF_FFFC); check32("wrap_pcp4", pc_plus4, 32'h0);
    instr_ready = 1; tick(); instr_ready = 0;
    @(negedge clk); check32("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a transaction.
    lat_mode = 3; imem_req_ready = 1; tick(); imem_req_ready = 0;
    @(negedge clk); check32("prerst_req", imem_req, 0);
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    check32("midrst_req", imem_req, 1); check32("midrst_addr", imem_addr, RST_PC);
    check32("midrst_instr", instr_out, NOP);

    // Misaligned redirect target.
    redirect_valid = 1; redirect_pc = 32'h102; tick(); redirect_valid = 0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    check32("mis_fault", fetch_fault, 1); check32("mis_req", imem_req, 0);
    imem_req_ready = 1; redirect_valid = 1; redirect_pc = 32'h300;
    repeat (3) tick();
    imem_req_ready = 0; redirect_valid = 0;
    @(negedge clk); check32("fault_req", imem_req, 0); check32("fault_sticky", fetch_fault, 1);
`else
    check32("mis_addr", imem_addr, 32'h100); check32("mis_fault", fetch_fault, 0);
`endif
    reset = 1; tick(); reset = 0;

    // Random traffic.
    lat_mode = -1;
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = $urandom_range(0, 1) != 0;
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; redirect_valid = 0;
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the datapath.
- Owns the PC and talks to instruction memory over a one-outstanding request/response handshake.
- Holds the fetched word and presents it to the datapath with valid/ready.
- Also drives the decoded register indices (rs1, rs2, rdi) that the register file consumes.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, value of instr_out when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  32  byte address of the request; always equals the internal pc.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  instr_out/pc_out are valid.
- instr_ready  input  1  datapath consumes the instruction this cycle.
- instr_out  output  32  held instruction.
- pc_out  output  32  PC of instr_out.
- pc_plus4  output  32  pc_out + 4, modulo 2^32.
- rs1  output  5  instr_out[19:15].
- rs2  output  5  instr_out[24:20].
- rdi  output  5  instr_out[11:7].
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  32  new PC.
- fetch_fault  output  1  misaligned redirect trap; see Optional Feature.

Behaviour:
- State machine with four states: REQ, WAIT, HOLD, FAULT. Internal registers: pc, drop flag, instr register.
- Reset values: state=REQ, pc=RESET_PC, drop=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC, fetch_fault=0.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_req_ready, go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rsp_valid with drop=1: clear drop, go to REQ, discard the data.
  - On imem_rsp_valid with drop=0: instr_out<=imem_rsp_data, pc_out<=pc, go to HOLD.
- HOLD:
  - instr_valid=1; instr_out and pc_out stay stable.
  - On instr_valid & instr_ready: pc<=pc+4 (wraps at 2^32), instr_valid<=0, instr_out<=NOP_INSTR, go to REQ.
- imem_rsp_valid is ignored outside WAIT.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory. Fetch-to-valid latency is 2 cycles from the REQ cycle.
- Redirect (redirect_valid=1) has priority over every other event in the same cycle:
  - pc<=redirect_pc with bits [1:0] forced to 0 (feature disabled).
  - instr_valid<=0, instr_out<=NOP_INSTR.
  - From REQ without imem_req_ready: go to REQ.
  - From REQ with imem_req_ready (old address accepted): go to WAIT with drop<=1.
  - From WAIT without rsp_valid: stay in WAIT with drop<=1.
  - From WAIT with rsp_valid: discard the data, go to REQ, drop<=0.
  - From HOLD, including when instr_ready=1: the instruction is not consumed; go to REQ.
- A second redirect while drop=1 only updates pc; drop stays 1.
- rs1/rs2/rdi are purely combinational slices of instr_out; the NOP gives 0/0/0.
- Reset mid-transaction returns to REQ. Instruction memory must be reset by the same signal; no stale response may arrive after reset.
- imem_req is never asserted in WAIT, HOLD or FAULT. Only one request is ever outstanding.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled: a redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1 (sticky until reset). pc<=redirect_pc unmodified, instr_valid<=0, state goes to FAULT. FAULT issues no requests and ignores responses and redirects. A pending WAIT response is absorbed without effect.
- Disabled: low two bits are forced to 0; fetch_fault is tied 0; FAULT is unreachable.

Test Plan:
- Reset, imem_req_ready=1, response 1 cycle later with data 32'h0020_81B3, instr_ready=1 -> imem_addr=0 on first request, instr_valid high 2 cycles after REQ, instr_out=32'h0020_81B3, rs1=1, rs2=2, rdi=3, pc_out=0, pc_plus4=4, next imem_addr=4.
- instr_ready held 0 for 5 cycles in HOLD -> instr_out and pc_out stable, imem_req=0 throughout; on ready, next imem_addr=pc_out+4.
- redirect_valid with redirect_pc=32'h100 in WAIT, stale response 32'hDEAD_BEEF 2 cycles later -> stale word never appears; next imem_addr=32'h100, drop cleared.
- redirect_pc=32'h200 asserted in HOLD with instr_ready=1 in the same cycle -> instr_valid=0 next cycle, next imem_addr=32'h200, no fetch at pc_out+4.
- pc=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000 (wrap); reset asserted in WAIT -> state REQ, imem_addr=RESET_PC, instr_out=NOP_INSTR.
- redirect_pc=32'h102: with FETCH_MISALIGN_TRAP_EN, fetch_fault=1 and imem_req stays 0 until reset; without the macro, next imem_addr=32'h100 and fetch_fault=0.
